// File: rtl/fft_fx_pkg.sv
// Shared fixed-point definitions for the FFT datapath blocks: default Q8.8 format,
// saturation limits and the fixed_divider state encoding.
package fft_fx_pkg;

   localparam int DEF_WORD_SIZE = 16;
   localparam int DEF_FRACTION  = 8;

   localparam logic [DEF_WORD_SIZE-1:0] Q_MAX = 16'h7FFF;
   localparam logic [DEF_WORD_SIZE-1:0] Q_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      DIV,
      FIX
   } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_restore_step #(
   parameter int RW = 17
) (
   input  logic [RW-1:0] rem_in,
   input  logic [RW-1:0] divisor,
   input  logic          bit_in,
   output logic [RW-1:0] rem_out,
   output logic          q_bit
);

   logic [RW:0] shifted;

   // The true remainder always fits in RW bits, so the low-bit difference is exact.
   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= {1'b0, divisor});
      rem_out = q_bit ? (shifted[RW-1:0] - divisor) : shifted[RW-1:0];
   end

endmodule

// File: rtl/fixed_divider.sv
// Sequential signed fixed-point divider (sign-magnitude restoring, one bit per clock).
// Define FIXED_DIVIDER_ROUND_EN to round half away from zero instead of truncating.
module fixed_divider
   import fft_fx_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int FRACTION  = DEF_FRACTION
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [WORD_SIZE-1:0] i_A,
   input  logic [WORD_SIZE-1:0] i_B,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [WORD_SIZE-1:0] o_quot,
   output logic                 o_ovf,
   output logic                 o_dbz
);

   localparam int N  = WORD_SIZE + 1 + FRACTION;
   localparam int MW = WORD_SIZE + 1;
`ifdef FIXED_DIVIDER_ROUND_EN
   localparam int QW = N + 1;
`else
   localparam int QW = N;
`endif
   localparam int CW = $clog2(QW + 1);

   localparam logic [CW-1:0]        CNT_INIT = CW'(QW - 1);
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic [MW-1:0]        MAG_ONE  = MW'(1);
   localparam logic [WORD_SIZE-1:0] W_ONE    = WORD_SIZE'(1);
   localparam logic [N:0]           POS_LIM  = (N+1)'((64'd1 << (WORD_SIZE-1)) - 64'd1);
   localparam logic [N:0]           NEG_LIM  = (N+1)'(64'd1 << (WORD_SIZE-1));
   localparam logic [WORD_SIZE-1:0] SAT_MAX  = {1'b0, {(WORD_SIZE-1){1'b1}}};
   localparam logic [WORD_SIZE-1:0] SAT_MIN  = {1'b1, {(WORD_SIZE-1){1'b0}}};

   div_state_t state_q, state_d;
   logic sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d;
   logic [MW-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d, rem_q, rem_d;
   logic [N-1:0] dividend_q, dividend_d;
   logic [QW-1:0] quot_q, quot_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ready_q, ready_d, valid_q, valid_d, ovf_q, ovf_d, out_dbz_q, out_dbz_d;
   logic [WORD_SIZE-1:0] out_quot_q, out_quot_d;

   logic [MW-1:0] a_ext, b_ext, step_rem;
   logic          step_bit, neg;
   logic [N:0]    qm;

   assign a_ext = {i_A[WORD_SIZE-1], i_A};
   assign b_ext = {i_B[WORD_SIZE-1], i_B};
   assign neg   = sa_q ^ sb_q;

   // With rounding the extra LSB of the quotient is the guard bit.
`ifdef FIXED_DIVIDER_ROUND_EN
   assign qm = {1'b0, quot_q[QW-1:1]} + {{N{1'b0}}, quot_q[0]};
`else
   assign qm = {1'b0, quot_q};
`endif

   div_restore_step #(
      .RW(MW)
   ) u_step (
      .rem_in (rem_q),
      .divisor(b_mag_q),
      .bit_in (dividend_q[N-1]),
      .rem_out(step_rem),
      .q_bit  (step_bit)
   );

   always_comb begin
      state_d    = state_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      dbz_d      = dbz_q;
      a_mag_d    = a_mag_q;
      b_mag_d    = b_mag_q;
      rem_d      = rem_q;
      dividend_d = dividend_q;
      quot_d     = quot_q;
      cnt_d      = cnt_q;
      ready_d    = ready_q;
      valid_d    = 1'b0;
      ovf_d      = ovf_q;
      out_dbz_d  = out_dbz_q;
      out_quot_d = out_quot_q;

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               sa_d    = i_A[WORD_SIZE-1];
               sb_d    = i_B[WORD_SIZE-1];
               a_mag_d = i_A[WORD_SIZE-1] ? (~a_ext + MAG_ONE) : a_ext;
               b_mag_d = i_B[WORD_SIZE-1] ? (~b_ext + MAG_ONE) : b_ext;
               dbz_d   = (i_B == '0);
               ready_d = 1'b0;
               state_d = PREP;
            end
         end
         PREP: begin
            dividend_d = {a_mag_q, {FRACTION{1'b0}}};
            rem_d      = '0;
            quot_d     = '0;
            cnt_d      = CNT_INIT;
            state_d    = DIV;
         end
         DIV: begin
            rem_d      = step_rem;
            quot_d     = {quot_q[QW-2:0], step_bit};
            dividend_d = {dividend_q[N-2:0], 1'b0};
            cnt_d      = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (dbz_q) begin
               out_quot_d = sa_q ? SAT_MIN : SAT_MAX;
               out_dbz_d  = 1'b1;
               ovf_d      = 1'b0;
            end else if (!neg && (qm > POS_LIM)) begin
               out_quot_d = SAT_MAX;
               out_dbz_d  = 1'b0;
               ovf_d      = 1'b1;
            end else if (neg && (qm > NEG_LIM)) begin
               out_quot_d = SAT_MIN;
               out_dbz_d  = 1'b0;
               ovf_d      = 1'b1;
            end else begin
               out_quot_d = neg ? (~qm[WORD_SIZE-1:0] + W_ONE) : qm[WORD_SIZE-1:0];
               out_dbz_d  = 1'b0;
               ovf_d      = 1'b0;
            end
            valid_d = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         dbz_q      <= 1'b0;
         a_mag_q    <= '0;
         b_mag_q    <= '0;
         rem_q      <= '0;
         dividend_q <= '0;
         quot_q     <= '0;
         cnt_q      <= '0;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         out_dbz_q  <= 1'b0;
         out_quot_q <= '0;
      end else begin
         state_q    <= state_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         dbz_q      <= dbz_d;
         a_mag_q    <= a_mag_d;
         b_mag_q    <= b_mag_d;
         rem_q      <= rem_d;
         dividend_q <= dividend_d;
         quot_q     <= quot_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         out_dbz_q  <= out_dbz_d;
         out_quot_q <= out_quot_d;
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_quot  = out_quot_q;
   assign o_ovf   = ovf_q;
   assign o_dbz   = out_dbz_q;

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider against an arithmetic reference model.
// Honours FIXED_DIVIDER_ROUND_EN the same way as the design.
module tb_fixed_divider;

   localparam int W = 16;
   localparam int F = 8;
`ifdef FIXED_DIVIDER_ROUND_EN
   localparam int LAT   = 28;
   localparam bit ROUND = 1'b1;
`else
   localparam int LAT   = 27;
   localparam bit ROUND = 1'b0;
`endif

   logic          i_clk   = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic [W-1:0]  i_A     = '0;
   logic [W-1:0]  i_B     = '0;
   logic          o_ready, o_valid, o_ovf, o_dbz;
   logic [W-1:0]  o_quot;

   int errors = 0;
   int checks = 0;

   fixed_divider #(
      .WORD_SIZE(W),
      .FRACTION (F)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .i_A    (i_A),
      .i_B    (i_B),
      .o_ready(o_ready),
      .o_valid(o_valid),
      .o_quot (o_quot),
      .o_ovf  (o_ovf),
      .o_dbz  (o_dbz)
   );

   always #5 i_clk = ~i_clk;

   // Real-valued division of the Q8.8 operands, rounded as the block promises.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic ovf, output logic dbz);
      longint sa, sb, am, bm, qm;
      bit neg;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      dbz = (sb == 0);
      ovf = 1'b0;
      if (dbz) begin
         q = (sa < 0) ? 16'h8000 : 16'h7FFF;
         return;
      end
      am  = (sa < 0) ? -sa : sa;
      bm  = (sb < 0) ? -sb : sb;
      neg = (sa < 0) != (sb < 0);
      if (ROUND) qm = (((am * 512) / bm) + 1) / 2;
      else       qm = (am * 256) / bm;
      if (!neg && qm > 32767) begin
         q = 16'h7FFF; ovf = 1'b1;
      end else if (neg && qm > 32768) begin
         q = 16'h8000; ovf = 1'b1;
      end else begin
         q = neg ? 16'(-qm) : 16'(qm);
      end
   endfunction

   // Drives one division from a negedge and collects the result; lat = -1 on timeout.
   task automatic do_division(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb,
                              output logic [W-1:0] q, output logic ovf, output logic dbz,
                              output int lat, output bit width_ok);
      int guard;
      guard = 0;
      while (!o_ready && guard < 200) begin
         @(negedge i_clk);
         guard++;
      end
      i_valid = 1'b1;
      i_A     = a;
      i_B     = b;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      lat     = 0;
      while (!o_valid && lat < LAT + 20) begin
         if (disturb) begin
            i_A     = 16'($urandom);
            i_B     = 16'($urandom);
            i_valid = (lat < LAT - 6) ? ($urandom_range(0, 1) == 1) : 1'b0;
         end
         @(negedge i_clk);
         lat++;
      end
      if (!o_valid) lat = -1;
      q   = o_quot;
      ovf = o_ovf;
      dbz = o_dbz;
      @(negedge i_clk);
      width_ok = !o_valid && (o_quot === q);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (3) @(negedge i_clk);
      checks += 5;
      if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", o_ready); end
      if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
      if (o_quot !== 16'h0000) begin errors++; $display("[TB] FAIL reset_quot: got %h expected 0000", o_quot); end
      if (o_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", o_ovf); end
      if (o_dbz !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b expected 0", o_dbz); end
      i_rst_n = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic test_directed();
      logic [W-1:0] da [11] = '{16'h0300, 16'hFD00, 16'h0200, 16'h8000, 16'h8000, 16'h7F00,
                                16'h8100, 16'h0100, 16'hFF00, 16'h0000, 16'hFE00};
      logic [W-1:0] db [11] = '{16'h0200, 16'h0200, 16'h0300, 16'h0100, 16'hFF00, 16'h0010,
                                16'h0010, 16'h0000, 16'h0000, 16'hFF00, 16'hFFFD};
      logic [W-1:0] q, eq;
      logic ovf, dbz, eovf, edbz;
      int lat;
      bit wok;
      for (int i = 0; i < 11; i++) begin
         do_division(da[i], db[i], 1'b0, q, ovf, dbz, lat, wok);
         ref_div(da[i], db[i], eq, eovf, edbz);
         checks += 5;
         if (q !== eq) begin errors++; $display("[TB] FAIL dir_quot %h/%h: got %h expected %h", da[i], db[i], q, eq); end
         if (ovf !== eovf) begin errors++; $display("[TB] FAIL dir_ovf %h/%h: got %b expected %b", da[i], db[i], ovf, eovf); end
         if (dbz !== edbz) begin errors++; $display("[TB] FAIL dir_dbz %h/%h: got %b expected %b", da[i], db[i], dbz, edbz); end
         if (lat != LAT) begin errors++; $display("[TB] FAIL dir_latency %h/%h: got %0d expected %0d", da[i], db[i], lat, LAT); end
         if (wok !== 1'b1) begin errors++; $display("[TB] FAIL dir_strobe %h/%h: got held=%b expected 1", da[i], db[i], wok); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, q, eq;
      logic ovf, dbz, eovf, edbz;
      int lat;
      bit wok;
      for (int i = 0; i < 16; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 64)) : 16'($urandom);
         do_division(a, b, 1'b1, q, ovf, dbz, lat, wok);
         ref_div(a, b, eq, eovf, edbz);
         checks += 4;
         if (q !== eq) begin errors++; $display("[TB] FAIL rnd_quot %h/%h: got %h expected %h", a, b, q, eq); end
         if (ovf !== eovf) begin errors++; $display("[TB] FAIL rnd_ovf %h/%h: got %b expected %b", a, b, ovf, eovf); end
         if (dbz !== edbz) begin errors++; $display("[TB] FAIL rnd_dbz %h/%h: got %b expected %b", a, b, dbz, edbz); end
         if (lat != LAT) begin errors++; $display("[TB] FAIL rnd_latency %h/%h: got %0d expected %0d", a, b, lat, LAT); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qa [4], qb [4], eq;
      logic eovf, edbz;
      int lat;
      for (int i = 0; i < 4; i++) begin
         qa[i] = 16'($urandom);
         qb[i] = 16'($urandom_range(1, 16'hFFFF));
      end
      i_valid = 1'b1;
      i_A     = qa[0];
      i_B     = qb[0];
      @(posedge i_clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         lat = 0;
         checks++;
         if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy %0d: got ready=%b expected 0", i, o_ready); end
         if (i < 3) begin
            i_A = qa[i+1];
            i_B = qb[i+1];
         end else begin
            i_valid = 1'b0;
         end
         while (!o_valid && lat < LAT + 20) begin
            @(negedge i_clk);
            lat++;
         end
         ref_div(qa[i], qb[i], eq, eovf, edbz);
         checks += 5;
         if (lat != LAT) begin errors++; $display("[TB] FAIL b2b_latency %0d: got %0d expected %0d", i, lat, LAT); end
         if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready %0d: got %b expected 1", i, o_ready); end
         if (o_quot !== eq) begin errors++; $display("[TB] FAIL b2b_quot %0d: got %h expected %h", i, o_quot, eq); end
         if (o_ovf !== eovf) begin errors++; $display("[TB] FAIL b2b_ovf %0d: got %b expected %b", i, o_ovf, eovf); end
         if (o_dbz !== edbz) begin errors++; $display("[TB] FAIL b2b_dbz %0d: got %b expected %b", i, o_dbz, edbz); end
         @(posedge i_clk);
      end
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tail_valid: got %b expected 0", o_valid); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] q, eq, a, b;
      logic ovf, dbz, eovf, edbz;
      int lat, stray;
      bit wok;
      do_division(16'h0300, 16'h0200, 1'b0, q, ovf, dbz, lat, wok);
      checks++;
      if (q !== 16'h0180) begin errors++; $display("[TB] FAIL mid_pre_quot: got %h expected 0180", q); end
      i_valid = 1'b1;
      i_A     = 16'h0200;
      i_B     = 16'h0300;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (11) @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      checks += 3;
      if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 1", o_ready); end
      if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", o_valid); end
      if (o_quot !== 16'h0000) begin errors++; $display("[TB] FAIL mid_quot: got %h expected 0000", o_quot); end
      i_rst_n = 1'b1;
      stray   = 0;
      repeat (LAT + 10) begin
         @(negedge i_clk);
         if (o_valid) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("[TB] FAIL mid_stray_valid: got %0d expected 0", stray); end
      a = 16'($urandom);
      b = 16'($urandom_range(1, 16'hFFFF));
      do_division(a, b, 1'b0, q, ovf, dbz, lat, wok);
      ref_div(a, b, eq, eovf, edbz);
      checks += 3;
      if (q !== eq) begin errors++; $display("[TB] FAIL mid_post_quot %h/%h: got %h expected %h", a, b, q, eq); end
      if (ovf !== eovf) begin errors++; $display("[TB] FAIL mid_post_ovf: got %b expected %b", ovf, eovf); end
      if (lat != LAT) begin errors++; $display("[TB] FAIL mid_post_latency: got %0d expected %0d", lat, LAT); end
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
